// File: rtl/wb_i2c_cmd_queue_pkg.sv
// Shared constants for the Wishbone I2C command queue:
// register offsets, bit positions, FSM states, defaults.
package wb_i2c_cmd_queue_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  localparam int CTRL_EN        = 8;
  localparam int CTRL_IRQ_EN    = 9;
  localparam int CTRL_RETRY_LSB = 10;

  localparam int ST_BUSY  = 8;
  localparam int ST_NACK  = 9;
  localparam int ST_OVF   = 10;
  localparam int ST_FULL  = 11;
  localparam int ST_EMPTY = 12;

  localparam int CLR_NACK  = 0;
  localparam int CLR_OVF   = 1;
  localparam int CLR_FLUSH = 2;

  localparam logic [6:0] DEF_DIV     = 7'd49;
  localparam logic [3:0] DEF_RETRIES = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_RUN,
    S_CHECK
  } state_t;

endpackage

// File: rtl/wb_i2c_cmd_queue_fifo.sv
// Circular FIFO of 16-bit I2C words with level/full/empty.
// Ports: push/pop/flush, data in/out, level, full, empty.
module i2c_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [15:0]   i_data,
  output logic [15:0]   o_data,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd];
  assign o_level = r_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_level <= r_level
               + (AW+1)'(w_push)
               - (AW+1)'(w_pop);
    end
  end

  // Storage needs no reset: pointers/level define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/wb_i2c_cmd_queue.sv
// Wishbone front-end queueing 16-bit I2C write words and
// launching them into an I2C write controller with NACK retry.
// Ports: clk/reset, Wishbone slave (wb_*), controller side
// (i2c_data, start, divisor, done, ack), level irq.
module wb_i2c_cmd_queue
  import wb_i2c_cmd_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int AW          = 2,
  parameter int ARM_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [15:0] i2c_data,
  output logic        start,
  output logic [6:0]  divisor,
  input  logic        done,
  input  logic        ack,
  output logic        irq
);

  localparam int TW = $clog2(ARM_TIMEOUT + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_i2c_data;
  logic [6:0]    r_div;
  logic          r_en;
  logic          r_irq_en;
  logic [3:0]    r_retries;
  logic [3:0]    r_try;
  logic [TW-1:0] r_timer;
  logic          r_nack;
  logic          r_ovf;
  logic          r_sent;

  logic          w_acc;
  logic          w_wr;
  logic [1:0]    w_reg;
  logic          w_push;
  logic          w_clr;
  logic          w_flush;
  logic [31:0]   w_rdata;
  logic [15:0]   w_head;
  logic [AW:0]   w_level;
  logic          w_full;
  logic          w_empty;
  logic          w_idle;
  logic          w_start;
  logic          w_pop;
  logic          w_load;
  logic          w_nack_set;
  logic          w_try_dec;
  logic [TW-1:0] w_timer_nxt;
  logic          w_unused;

  assign w_unused = ^{wb_dat_i[31:16], wb_adr_i[1:0]};

  assign w_acc   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign w_wr    = w_acc & wb_we_i;
  assign w_reg   = wb_adr_i[3:2];
  assign w_push  = w_wr & (w_reg == ADDR_DATA);
  assign w_clr   = w_wr & (w_reg == ADDR_CLEAR);
  assign w_idle  = (r_state == S_IDLE);
  assign w_flush = w_clr & wb_dat_i[CLR_FLUSH] & w_idle;

  i2c_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (wb_dat_i[15:0]),
    .o_data  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_timer_nxt = r_timer + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_nack_set  = 1'b0;
    w_try_dec   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A flush in the same clk wins over launching.
        if (r_en & ~w_empty & done & ~w_flush) begin
          w_load      = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_start     = 1'b1;
        w_state_nxt = S_ARM;
      end
      S_ARM: begin
        // done is still high from the previous transfer here;
        // only its fall proves the controller took the start.
        if (~done)
          w_state_nxt = S_RUN;
        else if (w_timer_nxt == TW'(ARM_TIMEOUT - 1))
          w_state_nxt = S_LAUNCH;
      end
      S_RUN: begin
        if (done) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (ack) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_try != 4'd0) begin
          w_try_dec   = 1'b1;
          w_state_nxt = S_LAUNCH;
        end else begin
          w_pop       = 1'b1;
          w_nack_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i2c_data <= '0;
      r_try      <= '0;
      r_timer    <= '0;
    end else begin
      if (w_load) begin
        r_i2c_data <= w_head;
        r_try      <= r_retries;
      end else if (w_try_dec) begin
        r_try <= r_try - 1'b1;
      end
      if (r_state == S_LAUNCH)  r_timer <= '0;
      else if (r_state == S_ARM) r_timer <= w_timer_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div     <= DEF_DIV;
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_retries <= DEF_RETRIES;
      r_nack    <= 1'b0;
      r_ovf     <= 1'b0;
      r_sent    <= 1'b0;
    end else begin
      if (w_wr & (w_reg == ADDR_CTRL)) begin
        r_div     <= wb_dat_i[6:0];
        r_en      <= wb_dat_i[CTRL_EN];
        r_irq_en  <= wb_dat_i[CTRL_IRQ_EN];
        r_retries <= wb_dat_i[CTRL_RETRY_LSB +: 4];
      end
      if (w_nack_set)
        r_nack <= 1'b1;
      else if (w_clr & wb_dat_i[CLR_NACK])
        r_nack <= 1'b0;
      if (w_push & w_full)
        r_ovf <= 1'b1;
      else if (w_clr & wb_dat_i[CLR_OVF])
        r_ovf <= 1'b0;
      if (w_pop)
        r_sent <= 1'b1;
      else if (w_clr)
        r_sent <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_reg)
      ADDR_STATUS: begin
        w_rdata[AW:0]     = w_level;
        w_rdata[ST_BUSY]  = ~w_idle;
        w_rdata[ST_NACK]  = r_nack;
        w_rdata[ST_OVF]   = r_ovf;
        w_rdata[ST_FULL]  = w_full;
        w_rdata[ST_EMPTY] = w_empty;
      end
      ADDR_CTRL: begin
        w_rdata[6:0]                = r_div;
        w_rdata[CTRL_EN]            = r_en;
        w_rdata[CTRL_IRQ_EN]        = r_irq_en;
        w_rdata[CTRL_RETRY_LSB +: 4] = r_retries;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= w_acc;
      if (w_acc) wb_dat_o <= wb_we_i ? 32'd0 : w_rdata;
    end
  end

  assign start    = w_start;
  assign i2c_data = r_i2c_data;
  assign divisor  = r_div;
  assign irq      = r_irq_en
                  & (r_nack | (w_empty & w_idle & r_sent));

endmodule

// File: tb/tb_wb_i2c_cmd_queue.sv
// Directed bench for wb_i2c_cmd_queue with a behavioural
// I2C controller model (done/ack) and a start monitor.
module tb_wb_i2c_cmd_queue;

  localparam int T = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [15:0] i2c_data;
  logic        start;
  logic [6:0]  divisor;
  logic        done = 1'b1;
  logic        ack = 1'b0;
  logic        irq;

  wb_i2c_cmd_queue #(
    .DEPTH       (4),
    .AW          (2),
    .ARM_TIMEOUT (T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .i2c_data (i2c_data),
    .start    (start),
    .divisor  (divisor),
    .done     (done),
    .ack      (ack),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Controller model and start monitor, both on negedge.
  int          cyc = 0;
  int          start_cnt = 0;
  int          viol = 0;
  logic [15:0] words [$];
  int          st_cyc [$];
  logic        ack_val = 1'b1;
  int          ign = 0;
  logic        mdl_busy = 1'b0;
  int          mdl_cnt = 0;
  logic        prev_start = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (start) begin
      if (mdl_busy || prev_start) viol++;
      start_cnt++;
      words.push_back(i2c_data);
      st_cyc.push_back(cyc);
      if (ign > 0) ign--;
      else begin
        mdl_busy = 1'b1;
        mdl_cnt = 0;
      end
    end else if (mdl_busy) begin
      mdl_cnt++;
      if (mdl_cnt == 3) done = 1'b0;
      if (mdl_cnt == 8) begin
        done = 1'b1;
        ack = ack_val;
        mdl_busy = 1'b0;
      end
    end
    prev_start = start;
  end

  task automatic wb_xfer(input logic we,
                         input logic [1:0] r,
                         input logic [31:0] d,
                         output logic [31:0] q);
    int k;
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = {r, 2'b00};
    wb_dat_i = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!wb_ack_o && k < 8);
    q = wb_dat_o;
    if (!wb_ack_o) check("wb_ack", 32'd0, 32'd1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [1:0] r,
                       input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, r, d, q);
  endtask

  task automatic wb_rd(input logic [1:0] r,
                       output logic [31:0] q);
    wb_xfer(1'b0, r, 32'd0, q);
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    while (start_cnt < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_idle(output logic [31:0] st);
    for (int k = 0; k < 1000; k++) begin
      wb_rd(2'd1, st);
      if (!st[8] && st[2:0] == 3'd0) break;
    end
  endtask

  task automatic clr_mon();
    words.delete();
    st_cyc.delete();
    start_cnt = 0;
  endtask

  logic [31:0] rd;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    wb_rd(2'd1, rd);
    check("rst_status", rd, 32'h0000_1000);
    wb_rd(2'd2, rd);
    check("rst_ctrl", rd, 32'h0000_0831);
    check("rst_div", {25'd0, divisor}, 32'd49);

    // two words, controller acks
    wb_wr(2'd0, 32'h0000_3412);
    wb_wr(2'd0, 32'h0000_5601);
    wb_rd(2'd1, rd);
    check("lvl2", rd, 32'h0000_0002);
    check("irq_off", {31'd0, irq}, 32'd0);
    wb_wr(2'd2, 32'h0000_0B31);
    wait_starts(2);
    wait_idle(rd);
    check("ack_status", rd, 32'h0000_1000);
    check("ack_starts", start_cnt, 32'd2);
    check("ack_w0", {16'd0, words[0]}, 32'h3412);
    check("ack_w1", {16'd0, words[1]}, 32'h5601);
    check("ack_irq", {31'd0, irq}, 32'd1);

    // persistent NACK, retries=2
    clr_mon();
    ack_val = 1'b0;
    wb_wr(2'd0, 32'h0000_7788);
    wait_starts(3);
    wait_idle(rd);
    check("nack_status", rd, 32'h0000_1200);
    check("nack_starts", start_cnt, 32'd3);
    check("nack_w2", {16'd0, words[2]}, 32'h7788);
    check("nack_irq", {31'd0, irq}, 32'd1);
    wb_wr(2'd3, 32'd1);
    wb_rd(2'd1, rd);
    check("nack_clr", rd, 32'h0000_1000);
    check("irq_clr", {31'd0, irq}, 32'd0);

    // first start ignored -> re-issue after timeout
    clr_mon();
    ack_val = 1'b1;
    ign = 1;
    wb_wr(2'd0, 32'h0000_1122);
    wait_starts(2);
    wait_idle(rd);
    check("to_status", rd, 32'h0000_1000);
    check("to_starts", start_cnt, 32'd2);
    check("to_gap", st_cyc[1] - st_cyc[0], T);
    check("to_w1", {16'd0, words[1]}, 32'h1122);

    // overflow with enable off, then drain
    wb_wr(2'd2, 32'h0000_0A31);
    for (int i = 0; i < 5; i++)
      wb_wr(2'd0, 32'h0000_A000 + i);
    wb_rd(2'd1, rd);
    check("ovf_status", rd, 32'h0000_0C04);
    clr_mon();
    wb_wr(2'd2, 32'h0000_0B31);
    wait_starts(4);
    wait_idle(rd);
    check("drain_status", rd, 32'h0000_1400);
    check("drain_starts", start_cnt, 32'd4);
    for (int i = 0; i < 4; i++)
      check("drain_w", {16'd0, words[i]}, 32'h0000_A000 + i);
    wb_wr(2'd3, 32'd2);
    wb_rd(2'd1, rd);
    check("ovf_clr", rd, 32'h0000_1000);

    // flush while idle
    wb_wr(2'd2, 32'h0000_0A31);
    wb_wr(2'd0, 32'h0000_BEEF);
    wb_wr(2'd3, 32'd4);
    wb_rd(2'd1, rd);
    check("flush", rd, 32'h0000_1000);

    // reset during RUN
    wb_wr(2'd2, 32'h0000_0B31);
    clr_mon();
    wb_wr(2'd0, 32'h0000_4455);
    wait_starts(1);
    for (int k = 0; k < 50 && done; k++) @(negedge clk);
    check("run_done_low", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_data", {16'd0, i2c_data}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wb_rd(2'd1, rd);
    check("rr_status", rd, 32'h0000_1000);
    wb_rd(2'd2, rd);
    check("rr_ctrl", rd, 32'h0000_0831);
    repeat (60) @(negedge clk);
    check("rr_starts", start_cnt, 32'd1);

    check("start_viol", viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
